// File: rtl/param_restoring_divider.sv
// Purpose: WIDTH-bit restoring divider, unsigned or signed (truncating), with div0/ovf flags.
// Latency: WIDTH edges from accept to out_valid; divide-by-zero completes on the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no pipelining.
module param_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH:0]   a;        // partial remainder, one guard bit
  logic [WIDTH-1:0] q;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] m;        // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             neg_q;    // operand signs differ in signed mode
  logic             neg_r;    // dividend negative in signed mode
  logic             ovf_pend; // signed MIN / -1 seen at accept

  logic [WIDTH+1:0] t;
  logic             t_neg;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);

  // One restoring iteration plus operand magnitudes and final sign correction.
  always_comb begin
    // Trial subtract on the shifted partial remainder; the extra top bit is the sign.
    t     = {a, q[WIDTH-1]} - {2'b00, m};
    t_neg = t[WIDTH+1];
    if (t_neg) begin
      a_nxt = {a[WIDTH-1:0], q[WIDTH-1]};
    end else begin
      a_nxt = t[WIDTH:0];
    end
    q_nxt = {q[WIDTH-2:0], ~t_neg};

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    dvd_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

    // MIN / -1 needs no special case: magnitude quotient 2^(WIDTH-1) reads back as MIN, remainder 0.
    q_fix = neg_q ? -q_nxt : q_nxt;
    r_fix = neg_r ? -a_nxt[WIDTH-1:0] : a_nxt[WIDTH-1:0];
  end

  // Control FSM, datapath registers and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m        <= dvs_mag;
            q        <= dvd_mag;
            a        <= '0;
            cnt      <= '0;
            neg_q    <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= signed_mode & dividend[WIDTH-1];
            ovf_pend <= signed_mode && (dividend == MIN_NEG) && (divisor == '1);
            if (divisor == '0) begin
              // Zero divisor skips the iterations entirely.
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              div0      <= 1'b1;
              ovf       <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          a   <= a_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST) begin
            state     <= DONE;
            quotient  <= q_fix;
            remainder <= r_fix;
            div0      <= 1'b0;
            ovf       <= ovf_pend;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_restoring_divider.sv
// Bench for param_restoring_divider: WIDTH=8 and WIDTH=16 instances against an integer reference.
// Directed cases (unsigned, signed, div0, ovf, backpressure, mid-op reset) then random 16-bit runs.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven there too.
module tb_param_restoring_divider;

  logic clk = 1'b0;
  logic rst;
  logic signed_mode;
  logic out_ready;

  logic        in_valid8, in_ready8, out_valid8, div0_8, ovf8, busy8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        in_valid16, in_ready16, out_valid16, div0_16, ovf16, busy16;
  logic [15:0] dvd16, dvs16, q16, r16;

  int checks = 0;
  int errors = 0;
  bit sel16 = 1'b0;

  logic        s_in_ready, s_out_valid, s_busy, s_d0, s_ov;
  logic [15:0] s_q, s_r;

  always #5 clk = ~clk;

  param_restoring_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dvd8), .divisor(dvs8), .signed_mode(signed_mode),
    .out_valid(out_valid8), .out_ready(out_ready), .quotient(q8), .remainder(r8),
    .div0(div0_8), .ovf(ovf8), .busy(busy8)
  );

  param_restoring_divider #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dvd16), .divisor(dvs16), .signed_mode(signed_mode),
    .out_valid(out_valid16), .out_ready(out_ready), .quotient(q16), .remainder(r16),
    .div0(div0_16), .ovf(ovf16), .busy(busy16)
  );

  // View of whichever instance the current step targets.
  always_comb begin
    if (sel16) begin
      s_in_ready = in_ready16; s_out_valid = out_valid16; s_busy = busy16;
      s_q = q16; s_r = r16; s_d0 = div0_16; s_ov = ovf16;
    end else begin
      s_in_ready = in_ready8; s_out_valid = out_valid8; s_busy = busy8;
      s_q = {8'h00, q8}; s_r = {8'h00, r8}; s_d0 = div0_8; s_ov = ovf8;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV int '/' and '%' truncate toward zero.
  function automatic void ref_div(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input bit sm, output logic [15:0] q, output logic [15:0] r,
                                  output bit d0, output bit ov);
    int mask, sa, sb, qi, ri;
    logic [15:0] am, bm, mk;
    mask = (1 << w) - 1;
    mk = mask[15:0];
    am = a & mk;
    bm = b & mk;
    d0 = 1'b0;
    ov = 1'b0;
    if (bm == 16'd0) begin
      q = mk; r = am; d0 = 1'b1;
    end else if (!sm) begin
      q = am / bm; r = am % bm;
    end else begin
      sa = am[w-1] ? int'(am) - (1 << w) : int'(am);
      sb = bm[w-1] ? int'(bm) - (1 << w) : int'(bm);
      if (sa == -(1 << (w-1)) && sb == -1) begin
        ov = 1'b1;
        qi = 1 << (w-1);
        q = qi[15:0];
        r = 16'd0;
      end else begin
        qi = sa / sb;
        ri = sa % sb;
        q = qi[15:0] & mk;
        r = ri[15:0] & mk;
      end
    end
  endfunction

  // Full transaction with out_ready held high; checks latency, busy time, result and return to IDLE.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b, input bit sm);
    logic [15:0] eq, er;
    bit ed, eo;
    int w, lat, bc;
    sel16 = w16;
    w = w16 ? 16 : 8;
    ref_div(w, a, b, sm, eq, er, ed, eo);
    out_ready = 1'b1;
    signed_mode = sm;
    if (w16) begin
      dvd16 = a; dvs16 = b; in_valid16 = 1'b1;
    end else begin
      dvd8 = a[7:0]; dvs8 = b[7:0]; in_valid8 = 1'b1;
    end
    check("in_ready_before_accept", s_in_ready, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    // Operands only matter on the accept edge.
    dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    dvd16 = 16'($urandom); dvs16 = 16'($urandom);
    signed_mode = 1'($urandom);
    lat = 0; bc = 0;
    while (!s_out_valid && lat < 64) begin
      if (s_busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    // Zero divisor result is already visible in the cycle right after the accept edge.
    check("latency", lat, ed ? 0 : w);
    check("busy_cycles", bc, ed ? 0 : w);
    check("quotient", s_q, eq);
    check("remainder", s_r, er);
    check("div0", s_d0, ed);
    check("ovf", s_ov, eo);
    @(posedge clk); #1;
    check("idle_after_handshake", {s_in_ready, s_out_valid, s_busy}, 3'b100);
    check("quotient_held_in_idle", s_q, eq);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    bit seen;
    int k;
    rst = 1'b0;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    dvd8 = '0; dvs8 = '0; dvd16 = '0; dvs16 = '0;
    signed_mode = 1'b0; out_ready = 1'b1;

    // Reset state of both instances.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      sel16 = (i == 1);
      #0;
      check("rst_handshake", {s_in_ready, s_out_valid, s_busy}, 3'b100);
      check("rst_results", {s_q, s_r, s_d0, s_ov}, 34'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned, zero divisor and signed directed cases (WIDTH=8).
    run_op(0, 16'd100, 16'd7, 0);
    check("u100_7", {s_q, s_r}, {16'd14, 16'd2});
    run_op(0, 16'd5, 16'd0, 0);
    check("div0_5", {s_q, s_r, s_d0}, {16'h00FF, 16'h0005, 1'b1});
    run_op(0, 16'h00F9, 16'd2, 1);
    check("s_m7_2", {s_q, s_r}, {16'h00FD, 16'h00FF});
    run_op(0, 16'd7, 16'h00FE, 1);
    check("s_7_m2", {s_q, s_r}, {16'h00FD, 16'h0001});
    run_op(0, 16'h0080, 16'h00FF, 1);
    check("s_ovf", {s_q, s_r, s_ov}, {16'h0080, 16'h0000, 1'b1});
    run_op(0, 16'h0080, 16'h0000, 1);
    run_op(0, 16'd255, 16'd1, 0);
    run_op(0, 16'd3, 16'd200, 0);

    // Backpressure: result held five cycles while inputs toggle.
    sel16 = 1'b0;
    out_ready = 1'b0; signed_mode = 1'b0;
    dvd8 = 8'd100; dvs8 = 8'd7; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("bp_done", {s_out_valid, s_q, s_r}, {1'b1, 16'd14, 16'd2});
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'($urandom); dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      @(posedge clk); #1;
      check("bp_hold_ctrl", {s_out_valid, s_in_ready, s_busy}, 3'b100);
      check("bp_hold_data", {s_q, s_r, s_d0, s_ov}, {16'd14, 16'd2, 2'b00});
    end
    out_ready = 1'b1; in_valid8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5;
    @(posedge clk); #1;
    check("bp_release_idle", {s_in_ready, s_out_valid, s_busy}, 3'b100);
    @(posedge clk); #1;
    check("bp_next_accepted", {s_in_ready, s_busy}, 2'b01);
    in_valid8 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("bp_next_result", {s_out_valid, s_q, s_r}, {1'b1, 16'd10, 16'd0});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    dvd8 = 8'd123; dvs8 = 8'd4; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_ctrl", {s_in_ready, s_out_valid, s_busy}, 3'b100);
    check("midrst_data", {s_q, s_r}, 32'd0);
    #2;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (s_out_valid || s_busy) seen = 1'b1;
    end
    check("midrst_no_output", seen, 1'b0);
    run_op(0, 16'd200, 16'd10, 0);
    check("after_rst_200_10", {s_q, s_r}, {16'd20, 16'd0});

    // WIDTH=16 directed edges, then random back-to-back operations.
    run_op(1, 16'hFFFF, 16'hFFFF, 0);
    check("u65535_65535", {s_q, s_r}, {16'd1, 16'd0});
    run_op(1, 16'h8000, 16'hFFFF, 1);
    run_op(1, 16'd1234, 16'd1, 0);
    run_op(1, 16'hFFFF, 16'd1, 0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      a = 16'($urandom);
      b = 16'($urandom);
      case (k)
        0: b = 16'd1;
        1: begin a = 16'($urandom_range(0, 1000)); b = 16'($urandom_range(1001, 65535)); end
        2: b = 16'd0;
        3: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(1, a, b, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
